// File: rtl/rf_writeback_unit.sv
// Register-file write-side arbiter: ALU results win the single write port,
// losing loads queue in an in-order FIFO, and pending-write hits feed decode stalls.
module rf_writeback_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [ADDR_W-1:0]           alu_rd,
  input  logic [DATA_W-1:0]           alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDR_W-1:0]           ld_rd,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        reg_write,
  output logic [ADDR_W-1:0]           write_register,
  output logic [DATA_W-1:0]           write_data,
  input  logic [ADDR_W-1:0]           read_reg_1,
  input  logic [ADDR_W-1:0]           read_reg_2,
  output logic                        pend_hit_1,
  output logic                        pend_hit_2,
  output logic [$clog2(DEPTH):0]      fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_register;
  logic [DATA_W-1:0] r_write_data;

  logic w_waw;
  logic w_hit_1;
  logic w_hit_2;
  logic w_alu_fire;
  logic w_ld_fire;
  logic w_empty;
  logic w_pop;
  logic w_bypass;
  logic w_push;

  // Occupied-entry address matches: WAW guard for the ALU and decode stall hits.
  always_comb begin
    w_waw   = 1'b0;
    w_hit_1 = 1'b0;
    w_hit_2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_vld[i] && (r_rd[i] == alu_rd))     w_waw   = 1'b1;
      if (r_vld[i] && (r_rd[i] == read_reg_1)) w_hit_1 = 1'b1;
      if (r_vld[i] && (r_rd[i] == read_reg_2)) w_hit_2 = 1'b1;
    end
  end

  assign alu_ready  = ~w_waw;
  assign ld_ready   = (r_count < CNT_W'(DEPTH));
  assign w_alu_fire = alu_valid & alu_ready;
  assign w_ld_fire  = ld_valid & ld_ready;
  assign w_empty    = (r_count == '0);
  assign w_pop      = ~w_alu_fire & ~w_empty;
  assign w_bypass   = ~w_alu_fire & w_empty & w_ld_fire;
  assign w_push     = w_ld_fire & ~w_bypass;

  assign pend_hit_1 = w_hit_1 | (r_reg_write & (r_write_register == read_reg_1));
  assign pend_hit_2 = w_hit_2 | (r_reg_write & (r_write_register == read_reg_2));

  assign reg_write      = r_reg_write;
  assign write_register = r_write_register;
  assign write_data     = r_write_data;
  assign fifo_count     = r_count;

  // FIFO payload storage; occupancy is tracked separately so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= ld_rd;
      r_data[r_wptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write      <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
      r_vld            <= '0;
      r_wptr           <= '0;
      r_rptr           <= '0;
      r_count          <= '0;
    end else begin
      if (w_alu_fire) begin
        r_reg_write      <= 1'b1;
        r_write_register <= alu_rd;
        r_write_data     <= alu_data;
      end else if (!w_empty) begin
        r_reg_write      <= 1'b1;
        r_write_register <= r_rd[r_rptr];
        r_write_data     <= r_data[r_rptr];
      end else if (w_ld_fire) begin
        r_reg_write      <= 1'b1;
        r_write_register <= ld_rd;
        r_write_data     <= ld_data;
      end else begin
        r_reg_write      <= 1'b0;
      end

      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PTR_W'(1);
      end
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Self-checking bench for rf_writeback_unit: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_rf_writeback_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, ld_valid;
  logic              alu_ready, ld_ready;
  logic [ADDR_W-1:0] alu_rd, ld_rd, read_reg_1, read_reg_2;
  logic [DATA_W-1:0] alu_data, ld_data;
  logic              reg_write, pend_hit_1, pend_hit_2;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic [2:0]        fifo_count;

  rf_writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
    .pend_hit_1(pend_hit_1), .pend_hit_2(pend_hit_2), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              m_q[$];
  logic              m_rw;
  logic [ADDR_W-1:0] m_wr;
  logic [DATA_W-1:0] m_wd;
  logic              t_afire, t_lfire;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_queued(input logic [ADDR_W-1:0] r);
    foreach (m_q[i]) if (m_q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_pend(input logic [ADDR_W-1:0] r);
    return m_queued(r) || (m_rw && (m_wr == r));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rw = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endtask

  // One clock: check handshake/hit outputs mid-cycle, advance model at the edge, check writes after.
  task automatic cycle();
    logic ar, lr;
    ent_t e;
    @(negedge clk);
    ar = !m_queued(alu_rd);
    lr = (m_q.size() < DEPTH);
    check("alu_ready", 64'(alu_ready), 64'(ar));
    check("ld_ready", 64'(ld_ready), 64'(lr));
    check("pend_hit_1", 64'(pend_hit_1), 64'(m_pend(read_reg_1)));
    check("pend_hit_2", 64'(pend_hit_2), 64'(m_pend(read_reg_2)));
    check("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    t_afire = alu_valid && ar;
    t_lfire = ld_valid && lr;
    @(posedge clk);
    if (t_afire) begin
      m_rw = 1'b1; m_wr = alu_rd; m_wd = alu_data;
      if (t_lfire) m_q.push_back('{ld_rd, ld_data});
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_rw = 1'b1; m_wr = e.rd; m_wd = e.data;
      if (t_lfire) m_q.push_back('{ld_rd, ld_data});
    end else if (t_lfire) begin
      m_rw = 1'b1; m_wr = ld_rd; m_wd = ld_data;
    end else begin
      m_rw = 1'b0;
    end
    #1;
    check("reg_write", 64'(reg_write), 64'(m_rw));
    check("write_register", 64'(write_register), 64'(m_wr));
    check("write_data", 64'(write_data), 64'(m_wd));
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int loads_sent;
    rst_n = 1'b0;
    alu_valid = 0; ld_valid = 0; alu_rd = '0; ld_rd = '0;
    alu_data = '0; ld_data = '0; read_reg_1 = '0; read_reg_2 = '0;
    model_reset();
    #3;
    check("rst_reg_write", 64'(reg_write), 64'(0));
    check("rst_write_register", 64'(write_register), 64'(0));
    check("rst_write_data", 64'(write_data), 64'(0));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ALU write and its one-cycle pulse
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_00AA;
    cycle();
    check("t1_rw", 64'(reg_write), 64'(1));
    check("t1_wr", 64'(write_register), 64'(3));
    check("t1_wd", 64'(write_data), 64'hAA);
    alu_valid = 0;
    cycle();
    check("t1_rw_off", 64'(reg_write), 64'(0));
    check("t1_cnt", 64'(fifo_count), 64'(0));

    // Simultaneous ALU and load: ALU first, load next
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h11;
    ld_valid  = 1; ld_rd  = 5'd6; ld_data  = 32'h22;
    cycle();
    check("t2_wr_alu", 64'(write_register), 64'(5));
    check("t2_cnt", 64'(fifo_count), 64'(1));
    alu_valid = 0; ld_valid = 0;
    cycle();
    check("t2_wr_ld", 64'(write_register), 64'(6));
    check("t2_wd_ld", 64'(write_data), 64'h22);
    check("t2_cnt0", 64'(fifo_count), 64'(0));

    // FIFO fills behind a stream of ALU writes, then drains in order
    loads_sent = 0;
    for (int i = 1; i <= 8; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'(32'h100 + i);
      ld_valid = (loads_sent < 5); ld_rd = 5'(16 + loads_sent); ld_data = 32'(32'hA00 + loads_sent);
      cycle();
      if (t_lfire) loads_sent++;
    end
    check("t3_cnt_full", 64'(fifo_count), 64'(4));
    check("t3_ld_ready", 64'(ld_ready), 64'(0));
    alu_valid = 0;
    for (int i = 0; i < 8; i++) begin
      ld_valid = (loads_sent < 5); ld_rd = 5'(16 + loads_sent); ld_data = 32'(32'hA00 + loads_sent);
      cycle();
      if (t_lfire) loads_sent++;
    end
    check("t3_all_loads", 64'(loads_sent), 64'(5));
    idle(2);

    // WAW: ALU to a register with a queued load waits for the load to retire
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid  = 1; ld_rd  = 5'd7; ld_data  = 32'h77;
    cycle();
    ld_valid = 0; alu_rd = 5'd7; alu_data = 32'h700;
    #1 check("t4_alu_blocked", 64'(alu_ready), 64'(0));
    cycle();
    check("t4_first_ld", 64'(write_data), 64'h77);
    check("t4_first_rd", 64'(write_register), 64'(7));
    cycle();
    check("t4_then_alu", 64'(write_data), 64'h700);
    idle(2);

    // Pending-hit flags for queued load and held output write
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h44;
    ld_valid  = 1; ld_rd  = 5'd9; ld_data  = 32'h99;
    cycle();
    alu_valid = 0; ld_valid = 0; read_reg_1 = 5'd9; read_reg_2 = 5'd4;
    #1;
    check("t5_hit1", 64'(pend_hit_1), 64'(1));
    check("t5_hit2", 64'(pend_hit_2), 64'(1));
    read_reg_1 = 5'd10;
    #1 check("t5_hit1_miss", 64'(pend_hit_1), 64'(0));
    idle(3);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'(i + 1); alu_data = 32'(32'h300 + i);
      ld_valid = 1; ld_rd = 5'(20 + i); ld_data = 32'(32'h500 + i);
      cycle();
    end
    check("t6_pre_cnt", 64'(fifo_count), 64'(3));
    check("t6_pre_rw", 64'(reg_write), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rw", 64'(reg_write), 64'(0));
    check("t6_wr", 64'(write_register), 64'(0));
    check("t6_wd", 64'(write_data), 64'(0));
    check("t6_cnt", 64'(fifo_count), 64'(0));
    model_reset();
    alu_valid = 0; ld_valid = 0;
    #1 rst_n = 1'b1;
    idle(4);

    // Random traffic; producers hold payload while stalled
    for (int n = 0; n < 400; n++) begin
      if (!(alu_valid && !t_afire)) begin
        alu_valid = ($urandom_range(0, 99) < 45);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!(ld_valid && !t_lfire)) begin
        ld_valid = ($urandom_range(0, 99) < 60);
        ld_rd    = 5'($urandom_range(0, 7));
        ld_data  = $urandom;
      end
      read_reg_1 = 5'($urandom_range(0, 7));
      read_reg_2 = 5'($urandom_range(0, 7));
      cycle();
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
